// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler: latches sound requests and plays them one at a time, lowest index first, with a silent gap after each tone
// Optional feature macro: SOUND_PREEMPT_EN (a strictly higher-priority request aborts the current tone or gap)
module sound_event_scheduler #(
    parameter int                    NREQ     = 4,
    parameter int                    DIV_W    = 8,
    parameter int                    DUR_W    = 24,
    parameter logic [NREQ*DIV_W-1:0] TONE_DIV = {8'd89, 8'd150, 8'd107, 8'd188},
    parameter logic [NREQ*DUR_W-1:0] TONE_DUR = {24'd6000000, 24'd1500000, 24'd3000000, 24'd10000000},
    parameter int                    GAP_CYC  = 120000
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [NREQ-1:0]  req,
    output logic             tone_en,
    output logic [DIV_W-1:0] tone_div,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             done,
    output logic [NREQ-1:0]  pending
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2;
    localparam logic [DUR_W-1:0] ONE = DUR_W'(1);
    localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_CYC);
    logic [1:0]       state, state_n;
    logic [DUR_W-1:0] timer, timer_n;
    logic [IW-1:0]    idx, idx_n, low;
    logic             load;
    logic [NREQ-1:0]  clr;

    // lowest pending index wins arbitration
    always_comb begin
        low = '0;
        for (int i = NREQ - 1; i >= 0; i--) if (pending[i]) low = IW'(i);
    end

`ifdef SOUND_PREEMPT_EN
    // idx still holds the last grant during GAP, so a gap is preemptible too
    assign load = |pending && (state == IDLE || low < idx);
`else
    assign load = |pending && state == IDLE;
`endif
    assign clr = load ? NREQ'(1) << low : '0;

    // next state, timer and selected requester
    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        if (load) begin
            state_n = PLAY;
            timer_n = TONE_DUR[low*DUR_W +: DUR_W];
            idx_n   = low;
        end else if (state == PLAY) begin
            state_n = timer == ONE ? GAP : PLAY;
            timer_n = timer == ONE ? GAP_LOAD : timer - ONE;
        end else if (state == GAP) begin
            state_n = timer == ONE ? IDLE : GAP;
            timer_n = timer == ONE ? '0 : timer - ONE;
        end
    end

    // registered state, request latch and outputs decoded from the next state
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            timer    <= '0;
            idx      <= '0;
            pending  <= '0;
            tone_en  <= 1'b0;
            tone_div <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            idx      <= idx_n;
            pending  <= (pending & ~clr) | req;
            tone_en  <= state_n == PLAY;
            tone_div <= state_n == PLAY ? TONE_DIV[idx_n*DIV_W +: DIV_W] : '0;
            grant    <= state_n == PLAY ? NREQ'(1) << idx_n : '0;
            busy     <= state_n != IDLE;
            done     <= state_n == PLAY && timer_n == ONE;
        end
    end
endmodule
